// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment type, hex glyph table and nibble decoder shared by the scan driver.
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    // {g,f,e,d,c,b,a}, active-high, glyphs 0-9 and A b C d E F
    localparam seg_t GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        return GLYPH[nibble];
    endfunction

endpackage

// File: rtl/seven_seg_glyph_rom.sv
// seven_seg_glyph_rom: combinational nibble to active-high segment pattern lookup.
module seven_seg_glyph_rom
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);

    assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seven_segment_scan_driver.sv
// seven_segment_scan_driver: time-multiplexed N-digit 7-segment driver with shadow capture,
// blanking, decimal points and leading-zero suppression; SEVEN_SEG_DEADTIME_EN adds anode dead time.
module seven_segment_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter int GUARD          = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic                    lzs_i,
    input  logic                    load_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? '1 : '0;
    localparam seg_t SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
`ifdef SEVEN_SEG_DEADTIME_EN
    localparam bit DEAD_EN = 1'b1;
`else
    localparam bit DEAD_EN = 1'b0;
`endif

    logic [PW-1:0]           pre_q, pre_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] val_q;
    logic [NUM_DIGITS-1:0]   dp_q, blank_q, upper_zero, sel, an_d, an_q;
    logic                    lzs_q, wrap, dark, zero_run, dp_d, dp_out_q;
    logic [3:0]              nibble;
    seg_t                    glyph, seg_d, seg_q;

    seven_seg_glyph_rom u_rom (
        .nibble_i (nibble),
        .seg_o    (glyph)
    );

    always_comb begin
        wrap     = pre_q == PW'(CLK_DIV - 1);
        pre_d    = wrap ? '0 : pre_q + 1'b1;
        idx_d    = !wrap ? idx_q : (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        nibble   = val_q[4*idx_q +: 4];
        zero_run = 1'b1;
        // upper_zero[i]: nibble i and every nibble above it are zero
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run & (val_q[4*i +: 4] == 4'h0);
            upper_zero[i] = zero_run;
        end
        dark  = blank_q[idx_q] | (lzs_q & upper_zero[idx_q] & (idx_q != '0));
        sel   = NUM_DIGITS'(1) << idx_q;
        an_d  = ((!DEAD_EN || pre_q >= PW'(GUARD)) ? sel : '0) ^ AN_OFF;
        seg_d = (dark ? '0 : glyph) ^ SEG_OFF;
        dp_d  = (dp_q[idx_q] & ~dark) ^ SEG_ACTIVE_LOW;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q    <= '0;
            idx_q    <= '0;
            val_q    <= '0;
            dp_q     <= '0;
            blank_q  <= '0;
            lzs_q    <= 1'b0;
            seg_q    <= SEG_OFF;
            dp_out_q <= SEG_ACTIVE_LOW;
            an_q     <= AN_OFF;
        end else begin
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            dp_out_q <= dp_d;
            an_q     <= an_d;
            if (load_i) begin
                val_q   <= value_i;
                dp_q    <= dp_i;
                blank_q <= blank_i;
                lzs_q   <= lzs_i;
            end
        end
    end

    assign seg_o = seg_q;
    assign dp_o  = dp_out_q;
    assign an_o  = an_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// tb_seven_segment_scan_driver: directed scoreboard bench, NUM_DIGITS=4, CLK_DIV=4.
module tb_seven_segment_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_i = '0;
    logic [3:0]  dp_i = '0, blank_i = '0;
    logic        lzs_i = 1'b0, load_i = 1'b0;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  an_o;

`ifdef SEVEN_SEG_DEADTIME_EN
    localparam bit DT = 1'b1;
`else
    localparam bit DT = 1'b0;
`endif

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;
    int   pos    = 0;

    always #5 clk = ~clk;

    seven_segment_scan_driver #(
        .NUM_DIGITS     (4),
        .CLK_DIV        (4),
        .SEG_ACTIVE_LOW (1'b0),
        .AN_ACTIVE_LOW  (1'b1),
        .GUARD          (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .value_i (value_i),
        .dp_i    (dp_i),
        .blank_i (blank_i),
        .lzs_i   (lzs_i),
        .load_i  (load_i),
        .seg_o   (seg_o),
        .dp_o    (dp_o),
        .an_o    (an_o)
    );

    // Expected anode pattern for the p-th edge after reset release.
    function automatic logic [3:0] an_exp(input int p);
        int d = (p / 4) % 4;
        if (DT && (p % 4) == 0) return 4'hF;
        return ~(4'b0001 << d);
    endfunction

    task automatic step(input logic [6:0] s, input logic p, input string nm);
        @(posedge clk);
        #1;
        q.push_back('{an_exp(pos), s, p, nm});
        pos++;
    endtask

    task automatic steps(input int n, input logic [6:0] s, input logic p, input string nm);
        repeat (n) step(s, p, nm);
    endtask

    task automatic rstep(input string nm);
        @(posedge clk);
        #1;
        q.push_back('{4'hF, 7'h00, 1'b0, nm});
        pos = 0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({an_o, seg_o, dp_o} !== {e.an, e.seg, e.dp}) begin
                    fails++;
                    $display("FAIL %s: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
                             e.nm, an_o, seg_o, dp_o, e.an, e.seg, e.dp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) rstep("reset");
        rst = 1'b0; load_i = 1'b1; value_i = 16'h1234;
        step(7'h3F, 1'b0, "release_d0");
        load_i = 1'b0;
        steps(3, 7'h66, 1'b0, "scan_d0");
        steps(4, 7'h4F, 1'b0, "scan_d1");
        steps(4, 7'h5B, 1'b0, "scan_d2");
        steps(4, 7'h06, 1'b0, "scan_d3");
        steps(4, 7'h66, 1'b0, "scan_wrap_d0");
        value_i = 16'h0050; lzs_i = 1'b1; load_i = 1'b1;
        step(7'h4F, 1'b0, "lzs_load");
        load_i = 1'b0;
        steps(3, 7'h6D, 1'b0, "lzs_d1");
        steps(8, 7'h00, 1'b0, "lzs_d23");
        steps(4, 7'h3F, 1'b0, "lzs_d0");
        value_i = 16'h0000; load_i = 1'b1;
        step(7'h6D, 1'b0, "zero_load");
        load_i = 1'b0;
        steps(3, 7'h00, 1'b0, "zero_d1");
        steps(8, 7'h00, 1'b0, "zero_d23");
        steps(4, 7'h3F, 1'b0, "zero_d0");
        value_i = 16'hABCD;
        steps(12, 7'h00, 1'b0, "hold_d123");
        steps(2, 7'h3F, 1'b0, "hold_d0");
        lzs_i = 1'b0; dp_i = 4'b0001; load_i = 1'b1;
        step(7'h3F, 1'b0, "mid_load");
        load_i = 1'b0;
        step(7'h5E, 1'b1, "mid_d0");
        steps(4, 7'h39, 1'b0, "dp_d1");
        steps(4, 7'h7C, 1'b0, "dp_d2");
        steps(4, 7'h77, 1'b0, "dp_d3");
        steps(4, 7'h5E, 1'b1, "dp_d0");
        blank_i = 4'b0100; load_i = 1'b1;
        step(7'h39, 1'b0, "blank_load");
        load_i = 1'b0;
        steps(3, 7'h39, 1'b0, "blank_d1");
        steps(2, 7'h00, 1'b0, "blank_d2");
        rst = 1'b1;
        rstep("rst_mid");
        rst = 1'b0; blank_i = 4'b0000;
        steps(4, 7'h3F, 1'b0, "restart_d0");
        step(7'h3F, 1'b0, "restart_d1");
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
